// File: rtl/add_seq_pkg.sv
// Shared definitions for the sliced add/subtract sequencer: FSM encoding,
// slice width and the counter-width helper.
package add_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count n items; never less than one so a single-slice
    // build still gets a legal counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/FullAdder16bit.sv
// 16-bit ripple-carry adder slice, shared by the sequencer across all chunks.
module FullAdder16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    logic c;

    // NOTE: every output of a combinational block gets a default before any
    // conditional or looped assignment, otherwise synthesis infers a latch.
    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

    assign cout = c;

endmodule

// File: rtl/add64_slice_sequencer.sv
// Multi-cycle add/subtract unit: one 16-bit slice walks the operands LSB chunk
// first, carrying between cycles, with valid/ready handshakes on both sides.
module add64_slice_sequencer
    import add_seq_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              busy
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = clog2(NSLICE);
    localparam int OFS_W  = clog2(SLICE_W);
    localparam int IDX_W  = CNT_W + OFS_W;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NSLICE - 1);

    state_t              state;
    logic [CNT_W-1:0]    k;
    logic                carry_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]   sum_reg;
    logic [DATA_W-1:0]   sum_next;
    logic [IDX_W-1:0]    base;
    logic [SLICE_W-1:0]  slice_a;
    logic [SLICE_W-1:0]  slice_b;
    logic [SLICE_W-1:0]  slice_s;
    logic                slice_cout;
    logic                accept;
    logic                last;
    logic                ovf_next;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign last      = (k == K_LAST);

    // Chunk k sits at bit offset k*SLICE_W.
    assign base    = {k, {OFS_W{1'b0}}};
    assign slice_a = a_reg[base +: SLICE_W];
    assign slice_b = b_reg[base +: SLICE_W];

    FullAdder16bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        sum_next                   = sum_reg;
        sum_next[base +: SLICE_W]  = slice_s;
    end

    // b_reg already holds the inverted operand for subtraction.
    assign ovf_next = (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                      (sum_next[DATA_W-1] != a_reg[DATA_W-1]);

    // NOTE: operand and working-sum registers carry no reset; they are always
    // written before being read, so only control state and outputs are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
        end
        if (state == CALC) begin
            sum_reg <= sum_next;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            carry_reg <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= CALC;
                        k         <= '0;
                        carry_reg <= in_sub | in_cin;
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    carry_reg <= slice_cout;
                    if (last) begin
                        state    <= DONE;
                        k        <= '0;
                        out_sum  <= sum_next;
                        out_cout <= slice_cout;
                        out_ovf  <= ovf_next;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add64_slice_sequencer.sv
// Self-checking bench: transaction-level reference model plus directed cases
// with literal expectations and a randomized valid/ready run.
module tb_add64_slice_sequencer;

    localparam int W  = 64;
    localparam int NS = W / 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;

    add64_slice_sequencer #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of an operation straight from the arithmetic: {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    // Transaction model: an accepted op produces its result NS edges later,
    // held until the consumer takes it; outputs keep the last result.
    int           m_cnt = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W+1:0] m_pend = '0;

    initial begin
        forever begin
            bit rdy;
            bit acc;
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_cnt   = 0;
                m_valid = 1'b0;
                m_sum   = '0;
                m_cout  = 1'b0;
                m_ovf   = 1'b0;
            end else begin
                rdy = (m_cnt == 0) && (!m_valid || out_ready);
                acc = in_valid && rdy;
                if (m_valid && out_ready) m_valid = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_valid = 1'b1;
                        {m_ovf, m_cout, m_sum} = m_pend;
                    end
                end
                if (acc) begin
                    m_pend = ref_add(in_a, in_b, in_cin, in_sub);
                    m_cnt  = NS;
                end
            end
        end
    end

    // Compare process: every cycle, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready",  64'(in_ready),  64'((m_cnt == 0) && (!m_valid || out_ready)));
                check("out_valid", 64'(out_valid), 64'(m_valid));
                check("busy",      64'(busy),      64'((m_cnt != 0) || m_valid));
                check("out_sum",   out_sum,        m_sum);
                check("out_cout",  64'(out_cout),  64'(m_cout));
                check("out_ovf",   64'(out_ovf),   64'(m_ovf));
            end
        end
    end

    // Back-to-back result monitor.
    bit           b2b_mon = 1'b0;
    logic [W-1:0] b2b_sum[$];
    int           b2b_cyc[$];
    initial begin
        forever begin
            @(negedge clk);
            if (b2b_mon && out_valid && out_ready) begin
                b2b_sum.push_back(out_sum);
                b2b_cyc.push_back(cyc);
            end
        end
    end

    // Present an op (caller is just after a rising edge) and wait until it is taken.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit keep, output int acc_cyc);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                if (!keep) in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int v_cyc);
        v_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                v_cyc = cyc;
                return;
            end
        end
        check("result_timeout", 64'(0), 64'(1));
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] e_sum,
                            input logic e_cout, input logic e_ovf);
        int ac;
        int vc;
        send(a, b, cin, sub, 1'b0, ac);
        wait_result(vc);
        check({name, "_latency"}, 64'(vc - ac), 64'(NS));
        check({name, "_sum"},  out_sum,        e_sum);
        check({name, "_cout"}, 64'(out_cout),  64'(e_cout));
        check({name, "_ovf"},  64'(out_ovf),   64'(e_ovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W+1:0] r;
        int ac;
        int vc;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;

        // Pin the model to hand-computed values.
        r = ref_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        check("model_carry", r, {2'b01, 64'h0});
        r = ref_add(64'h5, 64'h7, 1'b0, 1'b1);
        check("model_sub", r, {2'b00, 64'hFFFF_FFFF_FFFF_FFFE});
        r = ref_add(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        check("model_ovf", r, {2'b10, 64'h8000_0000_0000_0000});

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_out_sum",   out_sum,        64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        directed("carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        directed("sub",   64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        directed("ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Backpressure: result held while a stray request is presented.
        out_ready = 1'b0;
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, ac);
        wait_result(vc);
        check("bp_latency", 64'(vc - ac), 64'(NS));
        @(posedge clk);
        #1;
        in_a = 64'h1234; in_b = 64'h4321; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_ready", 64'(in_ready),  64'(0));
            check("bp_sum",   out_sum,        64'h0000_0001_0000_0000);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_no_accept_busy", 64'(busy), 64'(0));
        check("bp_sum_kept", out_sum, 64'h0000_0001_0000_0000);
        @(posedge clk);
        #1;

        // Back-to-back with the consumer always ready.
        b2b_mon = 1'b1;
        send(64'd1, 64'd1, 1'b0, 1'b0, 1'b1, ac);
        send(64'd2, 64'd2, 1'b0, 1'b0, 1'b1, ac);
        send(64'd3, 64'd3, 1'b0, 1'b0, 1'b0, ac);
        repeat (NS + 3) @(posedge clk);
        #1;
        b2b_mon = 1'b0;
        check("b2b_count", 64'(b2b_sum.size()), 64'(3));
        if (b2b_sum.size() == 3) begin
            check("b2b_r0", b2b_sum[0], 64'd2);
            check("b2b_r1", b2b_sum[1], 64'd4);
            check("b2b_r2", b2b_sum[2], 64'd6);
            check("b2b_gap0", 64'(b2b_cyc[1] - b2b_cyc[0]), 64'(NS + 1));
            check("b2b_gap1", 64'(b2b_cyc[2] - b2b_cyc[1]), 64'(NS + 1));
        end

        // Reset in the second CALC cycle aborts the op.
        send(64'd1, 64'd2, 1'b0, 1'b0, 1'b0, ac);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmid_busy",     64'(busy),      64'(0));
        check("rstmid_valid",    64'(out_valid), 64'(0));
        check("rstmid_in_ready", 64'(in_ready),  64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NS + 4; i++) begin
            @(negedge clk);
            check("rstmid_no_result", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Randomized traffic; the compare process does the checking.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = {$urandom, $urandom};
            in_b      = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: in_a = '1;
                1: in_b = '0;
                2: in_a = 64'h7FFF_FFFF_FFFF_FFFF;
                3: in_b = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            in_cin    = 1'($urandom_range(0, 1));
            in_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NS + 4) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/add64_slice_sequencer.md
Name: add64_slice_sequencer

Overview:
- Multi-cycle 64-bit add/subtract unit built from one shared 16-bit ripple-carry slice (existing FullAdder16bit), not four parallel slices.
- Sequences the operand through the slice one 16-bit chunk per cycle, least-significant first, and registers the carry between chunks.
- Valid/ready on both sides; sits between the RISC-V execute-stage issue logic and writeback as an area-reduced adder.

Parameters:
- DATA_W, 64, operand/result width; multiple of 16, range 16..256.
- NSLICE, DATA_W/16, derived slice count; not overridden by users.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B
- in_cin  in  1  carry-in; ignored when in_sub=1
- in_sub  in  1  1 = A-B (B inverted, carry-in forced 1)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  DATA_W  result
- out_cout  out  1  carry out of MSB; for sub, 1 = no borrow
- out_ovf  out  1  signed overflow
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, slice counter=0, carry reg=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, in_ready=1 on the first cycle after reset. Reset mid-operation aborts it; the result is discarded and no out_valid is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid, latch in_a, B' = in_sub ? ~in_b : in_b, and carry = in_sub ? 1 : in_cin. Clear the slice counter, then go to CALC.
- CALC: in_ready=0.
  - Each cycle, feed a_reg[16k+15:16k], b_reg[16k+15:16k] and the carry reg to the slice.
  - Write S into the sum register chunk k, store Cout into the carry reg, and increment k.
  - When k=NSLICE-1, go to DONE.
- DONE: out_valid=1, with out_sum, out_cout and out_ovf stable and held until out_ready.
  - out_ovf = (a[MSB]==B'[MSB]) && (sum[MSB]!=a[MSB]).
  - out_cout is the final carry reg.
- Latency: accept at edge T; out_valid rises after edge T+NSLICE (4 cycles for DATA_W=64). Throughput is one op per NSLICE+1 cycles without overlap.
- DONE with out_ready=1:
  - in_ready=1 in the same cycle (combinational in_ready = IDLE | (DONE & out_ready)).
  - If in_valid=1 as well, the result retires and the new op is latched in the same edge, going directly to CALC (back-to-back, no IDLE bubble).
  - If in_valid=0, go to IDLE.
- DONE with out_ready=0: hold all outputs and keep in_ready=0. Inputs are ignored (no overwrite).
- in_valid while in_ready=0: the request is not accepted; the requester must hold it (standard valid/ready).
- Outputs are registered; out_sum keeps its last value after retirement until the next DONE.
- Arithmetic is modulo 2^DATA_W; the carry chain wraps only via out_cout.

Decomposition:
- Shared package add_seq_pkg holds:
  - FSM state enum (IDLE, CALC, DONE, 2-bit encoding).
  - SLICE_W=16 localparam.
  - Slice-counter width function clog2(NSLICE).
- One sub-module instance: the existing FullAdder16bit as the shared slice; no new sub-module.
- Operand/sum shift or indexed registers and the FSM live in the top.

Test Plan:
- Reset mid-op:
  - Accept A=1, B=2. Assert rst_n=0 in the 2nd CALC cycle.
  - Next cycle: busy=0, out_valid=0, in_ready=1.
  - No out_valid is produced afterwards.
- Carry across all slices:
  - A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, sub=0, cin=0.
  - out_valid exactly 4 cycles after accept.
  - Expect out_sum=0, out_cout=1, out_ovf=0.
- Subtract with borrow:
  - A=0x5, B=0x7, sub=1.
  - Expect out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0, out_ovf=0.
- Signed overflow and cin:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=0x0, cin=1.
  - Expect out_sum=0x8000_0000_0000_0000, out_ovf=1, out_cout=0.
- Backpressure:
  - Result 0x0000_0001_0000_0000 (A=0x0000_0000_FFFF_FFFF, B=1) with out_ready=0 for 10 cycles.
  - out_valid and out_sum stay stable and in_ready=0 throughout.
  - A new in_valid presented in that window is not accepted.
- Back-to-back:
  - Hold out_ready=1 and present in_valid continuously with ops (1+1), (2+2), (3+3).
  - Results 2, 4, 6 appear at 5-cycle spacing with no IDLE cycle between ops.
